// File: rtl/sr_pulse_seq_pkg.sv
// Shared encodings for the set/reset pulse sequencer: FSM states and latch operations.
// Pure definitions, no logic and no latency.
// Nothing here carries flow control; see sr_pulse_seq for handshake behaviour.
package sr_pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_t;

  // Clear wins whenever it is requested, so a simultaneous set/clear resolves to CLR
  function automatic op_t pick_op(input logic clr_req);
    return clr_req ? OP_CLR : OP_SET;
  endfunction

endpackage

// File: rtl/sr_pulse_seq_if.sv
// Request/latch-drive bundle between a requester and the pulse sequencer.
// Wires only, no latency.
// Requester holds set/clr until req_ready; requests seen while busy are dropped.
interface sr_pulse_seq_if;

  logic set_req;
  logic clr_req;
  logic req_ready;
  logic preset_n;
  logic clear_n;
  logic q_model;
  logic q_valid;
  logic conflict;

  // Requester side
  modport master (
    output set_req,
    output clr_req,
    input  req_ready,
    input  preset_n,
    input  clear_n,
    input  q_model,
    input  q_valid,
    input  conflict
  );

  // Sequencer side
  modport slave (
    input  set_req,
    input  clr_req,
    output req_ready,
    output preset_n,
    output clear_n,
    output q_model,
    output q_valid,
    output conflict
  );

endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with zero flag, shared by the PULSE and GAP phases.
// Load/decrement take effect on the next clk edge; zero reflects the registered count.
// No backpressure; decrement saturates at zero.
module sr_pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority over decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_pulse_seq.sv
// Turns single-cycle set/clear requests into exclusive fixed-width low pulses for a NAND SR latch.
// Pulse starts the cycle after acceptance, lasts PW_CYCLES, then GAP_CYCLES of recovery.
// req_ready is low while a pulse or gap is in flight; requests seen then are dropped.
module sr_pulse_seq
  import sr_pulse_seq_pkg::*;
#(
  parameter int PW_CYCLES  = 3,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  sr_pulse_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t state_q, state_d;
  op_t    op_q, op_d;
  logic   preset_n_q, preset_n_d;
  logic   clear_n_q, clear_n_d;
  logic   req_ready_q, req_ready_d;
  logic   q_model_q, q_model_d;
  logic   q_valid_q, q_valid_d;
  logic   conflict_q, conflict_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  sr_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // FSM next state plus next values of every registered output. Pulse outputs are
  // derived only from the single op, so preset_n and clear_n can never both go low.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    preset_n_d  = preset_n_q;
    clear_n_d   = clear_n_q;
    req_ready_d = req_ready_q;
    q_model_d   = q_model_q;
    q_valid_d   = q_valid_q;
    conflict_d  = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = PW_LOAD;
    tmr_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.set_req || bus.clr_req) begin
          state_d     = PULSE;
          op_d        = pick_op(bus.clr_req);
          tmr_load    = 1'b1;
          tmr_val     = PW_LOAD;
          req_ready_d = 1'b0;
          conflict_d  = bus.set_req && bus.clr_req;
          preset_n_d  = (op_d != OP_SET);
          clear_n_d   = (op_d != OP_CLR);
        end
      end

      PULSE: begin
        if (tmr_zero) begin
          // Latch has now been driven for the full width; its state is known
          preset_n_d = 1'b1;
          clear_n_d  = 1'b1;
          q_model_d  = (op_q == OP_SET);
          q_valid_d  = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end else begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      GAP: begin
        if (tmr_zero) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        preset_n_d  = 1'b1;
        clear_n_d   = 1'b1;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output flops; reset releases the latch inputs immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_CLR;
      preset_n_q  <= 1'b1;
      clear_n_q   <= 1'b1;
      req_ready_q <= 1'b1;
      q_model_q   <= 1'b0;
      q_valid_q   <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      preset_n_q  <= preset_n_d;
      clear_n_q   <= clear_n_d;
      req_ready_q <= req_ready_d;
      q_model_q   <= q_model_d;
      q_valid_q   <= q_valid_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bus.preset_n  = preset_n_q;
  assign bus.clear_n   = clear_n_q;
  assign bus.req_ready = req_ready_q;
  assign bus.q_model   = q_model_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_sr_pulse_seq.sv
// Directed bench: two sequencers (PW=3/GAP=2 and PW=1/GAP=0) each driving a NAND latch model.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
// A negedge monitor watches pulse exclusivity and latch/model agreement throughout.
module tb_sr_pulse_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sr_pulse_seq_if a_if ();
  sr_pulse_seq_if b_if ();

  sr_pulse_seq #(.PW_CYCLES(3), .GAP_CYCLES(2), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  sr_pulse_seq #(.PW_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NAND SR latch models driven by the sequencer outputs
  logic a_latch_q;
  logic b_latch_q;
  initial begin
    a_latch_q = 1'b0;
    b_latch_q = 1'b0;
  end
  always @(a_if.preset_n or a_if.clear_n) begin
    if (!a_if.preset_n)     a_latch_q = 1'b1;
    else if (!a_if.clear_n) a_latch_q = 1'b0;
  end
  always @(b_if.preset_n or b_if.clear_n) begin
    if (!b_if.preset_n)     b_latch_q = 1'b1;
    else if (!b_if.clear_n) b_latch_q = 1'b0;
  end

  task automatic chk(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Continuous checks: never both latch inputs low; latch agrees with model once idle
  always @(negedge clk) begin
    if (!rst) begin
      chk("excl_a", a_if.preset_n | a_if.clear_n, 1'b1);
      chk("excl_b", b_if.preset_n | b_if.clear_n, 1'b1);
      if (a_if.q_valid && a_if.req_ready) chk("latch_a", a_latch_q, a_if.q_model);
      if (b_if.q_valid && b_if.req_ready) chk("latch_b", b_latch_q, b_if.q_model);
    end
  end

  initial begin
    logic ops [3];
    errors = 0;
    checks = 0;
    a_if.set_req = 1'b0;
    a_if.clr_req = 1'b0;
    b_if.set_req = 1'b0;
    b_if.clr_req = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_ready",    a_if.req_ready, 1'b1);
    chk("rst_preset",   a_if.preset_n,  1'b1);
    chk("rst_clear",    a_if.clear_n,   1'b1);
    chk("rst_qmodel",   a_if.q_model,   1'b0);
    chk("rst_qvalid",   a_if.q_valid,   1'b0);
    chk("rst_conflict", a_if.conflict,  1'b0);

    // Single set: 3 low, ready back 5 cycles after acceptance, q=1
    a_if.set_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) a_if.set_req = 1'b0;
      chk("set_preset", a_if.preset_n,  (k < 3) ? 1'b0 : 1'b1);
      chk("set_clear",  a_if.clear_n,   1'b1);
      chk("set_ready",  a_if.req_ready, (k == 5) ? 1'b1 : 1'b0);
      chk("set_qmodel", a_if.q_model,   (k >= 3) ? 1'b1 : 1'b0);
      chk("set_qvalid", a_if.q_valid,   (k >= 3) ? 1'b1 : 1'b0);
      chk("set_confl",  a_if.conflict,  1'b0);
    end

    // Simultaneous set+clear: clear wins, conflict for one cycle
    a_if.set_req = 1'b1;
    a_if.clr_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) begin
        a_if.set_req = 1'b0;
        a_if.clr_req = 1'b0;
      end
      chk("both_clear",  a_if.clear_n,   (k < 3) ? 1'b0 : 1'b1);
      chk("both_preset", a_if.preset_n,  1'b1);
      chk("both_confl",  a_if.conflict,  (k == 0) ? 1'b1 : 1'b0);
      chk("both_qmodel", a_if.q_model,   (k >= 3) ? 1'b0 : 1'b1);
      chk("both_ready",  a_if.req_ready, (k == 5) ? 1'b1 : 1'b0);
    end

    // Set held high: period 6 (3 low, 2 gap, 1 idle); clear during pulse ignored
    a_if.set_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 1) a_if.clr_req = 1'b1;
      if (k == 2) a_if.clr_req = 1'b0;
      chk("hold_preset", a_if.preset_n, ((k % 6) < 3) ? 1'b0 : 1'b1);
      chk("hold_clear",  a_if.clear_n,  1'b1);
    end
    a_if.set_req = 1'b0;
    chk("hold_qmodel", a_if.q_model, 1'b1);

    // PW=1, GAP=0: alternating set/clear, q toggles 1,0,1
    ops[0] = 1'b1;
    ops[1] = 1'b0;
    ops[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_if.set_req = ops[i];
      b_if.clr_req = ~ops[i];
      step();
      b_if.set_req = 1'b0;
      b_if.clr_req = 1'b0;
      chk("alt_preset0", b_if.preset_n,  ~ops[i]);
      chk("alt_clear0",  b_if.clear_n,   ops[i]);
      chk("alt_ready0",  b_if.req_ready, 1'b0);
      step();
      chk("alt_preset1", b_if.preset_n,  1'b1);
      chk("alt_clear1",  b_if.clear_n,   1'b1);
      chk("alt_ready1",  b_if.req_ready, 1'b1);
      chk("alt_qmodel",  b_if.q_model,   ops[i]);
      chk("alt_qvalid",  b_if.q_valid,   1'b1);
    end

    // Async reset in the second cycle of a clear pulse
    a_if.clr_req = 1'b1;
    step();
    a_if.clr_req = 1'b0;
    chk("mid_clear0", a_if.clear_n, 1'b0);
    step();
    chk("mid_clear1", a_if.clear_n, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clear",  a_if.clear_n,   1'b1);
    chk("arst_preset", a_if.preset_n,  1'b1);
    chk("arst_ready",  a_if.req_ready, 1'b1);
    chk("arst_qvalid", a_if.q_valid,   1'b0);
    chk("arst_qmodel", a_if.q_model,   1'b0);
    chk("arst_confl",  a_if.conflict,  1'b0);
    #3;
    rst = 1'b0;
    step();

    // Next request after reset gets a full-width pulse
    a_if.set_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) a_if.set_req = 1'b0;
      chk("post_preset", a_if.preset_n,  (k < 3) ? 1'b0 : 1'b1);
      chk("post_ready",  a_if.req_ready, (k == 5) ? 1'b1 : 1'b0);
      chk("post_qvalid", a_if.q_valid,   (k >= 3) ? 1'b1 : 1'b0);
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
